debounce_ctrl: RTL and testbench
================================

DEBOUNCE_CTRL -- requirements
Module: debounce_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 4, number of debounced input channels (1..16).
REQ-002 SHALL have parameter TICK_DIV, default 16'hC350, terminal count of the sample-tick divider (tick period = TICK_DIV+1 CLK cycles).
REQ-003 SHALL have parameter STABLE_CNT, default 4, consecutive differing samples required to accept a level change (2..15).
REQ-004 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port EN  input  1  sampling enable; 0 freezes tick divider and channel counters.
REQ-007 SHALL have port BTN_IN  input  NCH  raw, asynchronous button/switch levels.
REQ-008 SHALL have port BTN_OUT  output  NCH  debounced levels.
REQ-009 SHALL have port BTN_RISE  output  NCH  one-cycle pulse on a 0->1 change of BTN_OUT.
REQ-010 SHALL have port BTN_FALL  output  NCH  one-cycle pulse on a 1->0 change of BTN_OUT.
REQ-011 SHALL have port SAMPLE_TICK  output  1  one-cycle sample strobe, for observation and chaining.

Function
REQ-012 SHALL pass each BTN_IN bit through a 2-flop synchronizer before use; the synchronized value is the "sample".
REQ-013 Tick divider: 16-bit counter; when EN=1, it increments each cycle, and at count==TICK_DIV it wraps to 0 with SAMPLE_TICK=1 for exactly that cycle; otherwise SAMPLE_TICK=0.
REQ-014 While EN=0, SHALL clear the divider counter to 0 and hold SAMPLE_TICK=0; the first tick after EN rises comes TICK_DIV+1 cycles later.
REQ-015 Per channel, SHALL keep a 4-bit count; act only on cycles with SAMPLE_TICK=1.
REQ-016 On a tick with sample==BTN_OUT[i]: count[i] cleared to 0 (bounce rejection).
REQ-017 On a tick with sample!=BTN_OUT[i] and count[i]<STABLE_CNT-1: count[i] increments.
REQ-018 On a tick with sample!=BTN_OUT[i] and count[i]==STABLE_CNT-1: SHALL register BTN_OUT[i] <= sample and count[i] <= 0, with the matching BTN_RISE[i]/BTN_FALL[i] asserted in the same registered cycle for one cycle only.
REQ-019 Latency: BTN_OUT update occurs at the STABLE_CNT-th consecutive differing tick; from a clean BTN_IN edge, worst case is 2 + STABLE_CNT*(TICK_DIV+1) cycles.
REQ-020 Channels SHALL be independent; simultaneous updates on several channels in one cycle are allowed and all reported.
REQ-021 BTN_RISE and BTN_FALL of one channel SHALL never be asserted together; with no tick they SHALL be 0.
REQ-022 Count SHALL never exceed STABLE_CNT-1 (no wrap).

Reset
REQ-023 RST=1 SHALL asynchronously clear synchronizer flops, divider counter, all counts, BTN_OUT, BTN_RISE, BTN_FALL and SAMPLE_TICK to 0.
REQ-024 Reset asserted mid-count SHALL discard partial counts; after release, debouncing restarts from BTN_OUT=0.
REQ-025 After RST release with EN=1, the first SAMPLE_TICK SHALL occur on the (TICK_DIV+1)-th rising CLK edge.

Structure
REQ-026 TICK_DIV default, counter widths and STABLE_CNT limits SHALL live in a shared constants package used by all debounce blocks.
REQ-027 The tick divider SHALL be a separate sub-module, sample_tick_gen (CLK, RST, EN, TICK); per-channel logic SHALL be a generate loop inside debounce_ctrl.

Verification (TICK_DIV=9, STABLE_CNT=4, NCH=4)
REQ-028 Reset release, EN=1, BTN_IN=0 -> SAMPLE_TICK at cycles 10, 20, 30...; all outputs 0.
REQ-029 BTN_IN[0] 0->1 held -> BTN_OUT[0]=1 at the 4th tick seeing synced 1; BTN_RISE[0] high exactly 1 cycle; other channels unaffected.
REQ-030 BTN_IN[1] high for 3 ticks then low -> BTN_OUT[1] stays 0, no pulses; subsequent clean press needs 4 fresh ticks.
REQ-031 BTN_IN[2] 0->1 and BTN_IN[3] 1->0 (after settling at 1) on same cycle -> BTN_RISE[2] and BTN_FALL[3] in the same cycle.
REQ-032 EN=0 after 2 differing ticks -> no ticks, counts held; EN=1 -> update after 2 more ticks. RST pulse mid-count -> all outputs 0 immediately, count restarts.

Source files
------------

// File: rtl/debounce_ctrl_pkg.sv
// Shared constants for the debounce blocks: divider/counter widths,
// default sample period and the legal range of the stability count.
package debounce_ctrl_pkg;

  // Width of the sample-tick divider counter.
  localparam int unsigned DIV_W = 16;

  // Width of each per-channel stability counter.
  localparam int unsigned CNT_W = 4;

  // Default divider terminal count (tick period = TICK_DIV + 1 clocks).
  localparam logic [DIV_W-1:0] TICK_DIV_DEF = 16'hC350;

  // Default number of consecutive differing samples needed to accept a change.
  localparam int unsigned STABLE_CNT_DEF = 4;

  // Legal range of the stability count; the upper bound keeps the
  // terminal count representable in CNT_W bits.
  localparam int unsigned STABLE_CNT_MIN = 2;
  localparam int unsigned STABLE_CNT_MAX = 15;

  // Terminal value of a channel counter for a given stability count,
  // clamped into the legal range so an out-of-range parameter can never
  // produce a counter that wraps.
  function automatic logic [CNT_W-1:0] stable_last(input int unsigned stable_cnt);
    int unsigned c;
    c = stable_cnt;
    if (c < STABLE_CNT_MIN) c = STABLE_CNT_MIN;
    if (c > STABLE_CNT_MAX) c = STABLE_CNT_MAX;
    return CNT_W'(c - 1);
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-tick divider: emits a one-cycle TICK every TICK_DIV+1 enabled
// clocks. The counter is held at zero while EN is low so that the first
// tick after enabling is always a full period away.
module sample_tick_gen
  import debounce_ctrl_pkg::*;
#(
  parameter logic [DIV_W-1:0] TICK_DIV = TICK_DIV_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  output logic TICK
);

  logic [DIV_W-1:0] count;

  // Divider counter with registered tick on the wrap cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
      TICK  <= 1'b0;
    end else if (!EN) begin
      count <= '0;
      TICK  <= 1'b0;
    end else if (count == TICK_DIV) begin
      count <= '0;
      TICK  <= 1'b1;
    end else begin
      count <= count + DIV_W'(1);
      TICK  <= 1'b0;
    end
  end

endmodule

// File: rtl/debounce_ctrl.sv
// Multi-channel button/switch debouncer. Each raw input is synchronized,
// then sampled once per SAMPLE_TICK; a level change is accepted only after
// STABLE_CNT consecutive samples that differ from the current debounced
// level. Any sample matching the current level restarts the count.
module debounce_ctrl
  import debounce_ctrl_pkg::*;
#(
  parameter int unsigned      NCH        = 4,
  parameter logic [DIV_W-1:0] TICK_DIV   = TICK_DIV_DEF,
  parameter int unsigned      STABLE_CNT = STABLE_CNT_DEF
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           EN,
  input  logic [NCH-1:0] BTN_IN,
  output logic [NCH-1:0] BTN_OUT,
  output logic [NCH-1:0] BTN_RISE,
  output logic [NCH-1:0] BTN_FALL,
  output logic           SAMPLE_TICK
);

  // Counter value at which the next differing sample is accepted.
  localparam logic [CNT_W-1:0] LAST = stable_last(STABLE_CNT);

  // Synchronizer stages; sync_p1 is the sample used by the channel logic.
  logic [NCH-1:0] sync_p0;
  logic [NCH-1:0] sync_p1;

  // Two-flop synchronizer for the asynchronous button levels.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= BTN_IN;
      sync_p1 <= sync_p0;
    end
  end

  // Shared sample strobe for all channels.
  sample_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (EN),
    .TICK (SAMPLE_TICK)
  );

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CNT_W-1:0] count;
    logic             level;
    logic             rise;
    logic             fall;

    // Per-channel stability counter, debounced level and edge pulses.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        count <= '0;
        level <= 1'b0;
        rise  <= 1'b0;
        fall  <= 1'b0;
      end else begin
        rise <= 1'b0;
        fall <= 1'b0;
        if (SAMPLE_TICK) begin
          if (sync_p1[i] == level) begin
            // Sample agrees with the current level: treat as bounce.
            count <= '0;
          end else if (count >= LAST) begin
            // Enough consecutive differing samples: accept the new level.
            count <= '0;
            level <= sync_p1[i];
            rise  <= sync_p1[i];
            fall  <= ~sync_p1[i];
          end else begin
            count <= count + CNT_W'(1);
          end
        end
      end
    end

    assign BTN_OUT[i]  = level;
    assign BTN_RISE[i] = rise;
    assign BTN_FALL[i] = fall;
  end

endmodule

// File: tb/tb_debounce_ctrl.sv
// Bench for debounce_ctrl with TICK_DIV=9, STABLE_CNT=4, NCH=4.
// A cycle-level reference model predicts all outputs; directed scenarios
// add hand-computed expectations for tick timing and debounce latency.
module tb_debounce_ctrl;

  localparam int          NCH      = 4;
  localparam logic [15:0] TICK_DIV = 16'd9;
  localparam int          SC       = 4;
  localparam int          PERIOD   = int'(TICK_DIV) + 1;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           EN = 1'b0;
  logic [NCH-1:0] BTN_IN = '0;
  logic [NCH-1:0] BTN_OUT;
  logic [NCH-1:0] BTN_RISE;
  logic [NCH-1:0] BTN_FALL;
  logic           SAMPLE_TICK;

  debounce_ctrl #(
    .NCH        (NCH),
    .TICK_DIV   (TICK_DIV),
    .STABLE_CNT (SC)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .EN          (EN),
    .BTN_IN      (BTN_IN),
    .BTN_OUT     (BTN_OUT),
    .BTN_RISE    (BTN_RISE),
    .BTN_FALL    (BTN_FALL),
    .SAMPLE_TICK (SAMPLE_TICK)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Inputs are seen by the channels two clocks late; a tick is due on every
  // PERIOD-th enabled clock; a channel flips once its last SC tick samples
  // since the previous flip all disagree with its current level.
  logic [NCH-1:0] d1 = '0, d2 = '0;
  logic [NCH-1:0] m_out = '0, m_rise = '0, m_fall = '0;
  bit             m_tick = 1'b0;
  int             en_cycles = 0;
  logic [SC-1:0]  win [NCH] = '{default: '0};
  int             since [NCH] = '{default: 0};

  initial forever begin
    @(posedge CLK or posedge RST);
    if (RST) begin
      d1 = '0; d2 = '0; m_out = '0; m_rise = '0; m_fall = '0;
      m_tick = 1'b0; en_cycles = 0;
      for (int i = 0; i < NCH; i++) begin win[i] = '0; since[i] = 0; end
    end else begin
      m_rise = '0; m_fall = '0;
      if (m_tick) begin
        for (int i = 0; i < NCH; i++) begin
          win[i] = {win[i][SC-2:0], d2[i]};
          since[i]++;
          if (since[i] >= SC && win[i] == {SC{~m_out[i]}}) begin
            m_out[i]  = ~m_out[i];
            m_rise[i] = m_out[i];
            m_fall[i] = ~m_out[i];
            since[i]  = 0;
          end
        end
      end
      d2 = d1;
      d1 = BTN_IN;
      if (EN) begin
        en_cycles++;
        m_tick = (en_cycles % PERIOD) == 0;
      end else begin
        en_cycles = 0;
        m_tick = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge CLK);
    if (chk_on) begin
      check("sample_tick", 32'(SAMPLE_TICK), 32'(m_tick));
      check("btn_out", 32'(BTN_OUT), 32'(m_out));
      check("btn_rise", 32'(BTN_RISE), 32'(m_rise));
      check("btn_fall", 32'(BTN_FALL), 32'(m_fall));
      check("rise_fall_excl", 32'(BTN_RISE & BTN_FALL), 32'd0);
    end
  end

  // ---------------- helpers ----------------
  task automatic drive_slot();
    @(posedge CLK);
    #2;
  endtask

  // Observe n negedges; index k-1 is the edge count since the preceding posedge.
  task automatic watch(input int n, input int ch, output int nr, output int nf,
                       output int er, output int ef, output int nt, output int ft);
    nr = 0; nf = 0; er = -1; ef = -1; nt = 0; ft = -1;
    for (int k = 1; k <= n; k++) begin
      @(negedge CLK);
      if (BTN_RISE[ch]) begin nr++; if (er < 0) er = k - 1; end
      if (BTN_FALL[ch]) begin nf++; if (ef < 0) ef = k - 1; end
      if (SAMPLE_TICK)  begin nt++; if (ft < 0) ft = k - 1; end
    end
  endtask

  task automatic wait_tick(input string nm);
    int k;
    for (k = 0; k < 3 * PERIOD; k++) begin
      @(negedge CLK);
      if (SAMPLE_TICK) break;
    end
    check(nm, 32'(k < 3 * PERIOD), 32'd1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int nr, nf, er, ef, nt, ft;
    int er2, ef3;

    // Reset state.
    repeat (3) @(negedge CLK);
    check("reset_out", 32'(BTN_OUT), 32'd0);
    check("reset_rise", 32'(BTN_RISE), 32'd0);
    check("reset_fall", 32'(BTN_FALL), 32'd0);
    check("reset_tick", 32'(SAMPLE_TICK), 32'd0);
    chk_on = 1'b1;

    // Release with EN=1: ticks on the 10th, 20th ... edge.
    drive_slot();
    RST = 1'b0;
    EN  = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (k == 9 || k == 10 || k == 11 || k == 20)
        check($sformatf("tick_at_edge_%0d", k), 32'(SAMPLE_TICK), 32'(k % 10 == 0));
    end

    // Clean press on channel 0.
    drive_slot();
    BTN_IN[0] = 1'b1;
    watch(60, 0, nr, nf, er, ef, nt, ft);
    check("ch0_rise_count", 32'(nr), 32'd1);
    check("ch0_fall_count", 32'(nf), 32'd0);
    check("ch0_latency_window", 32'(er >= 31 && er <= 42), 32'd1);
    check("ch0_out", 32'(BTN_OUT), 32'b0001);

    // Channel 1 held high for only three sampled ticks, then released.
    drive_slot();
    BTN_IN[1] = 1'b1;
    watch(28, 1, nr, nf, er, ef, nt, ft);
    check("ch1_bounce_no_rise", 32'(nr), 32'd0);
    drive_slot();
    BTN_IN[1] = 1'b0;
    watch(20, 1, nr, nf, er, ef, nt, ft);
    check("ch1_bounce_no_pulse", 32'(nr + nf), 32'd0);
    check("ch1_bounce_out", 32'(BTN_OUT[1]), 32'd0);

    // Clean press on channel 1 needs four fresh ticks.
    drive_slot();
    BTN_IN[1] = 1'b1;
    watch(60, 1, nr, nf, er, ef, nt, ft);
    check("ch1_press_rise_count", 32'(nr), 32'd1);
    check("ch1_press_fresh_ticks", 32'(er >= 31 && er <= 42), 32'd1);

    // Settle channel 3 high, then flip channels 2 and 3 together.
    drive_slot();
    BTN_IN[3] = 1'b1;
    watch(50, 3, nr, nf, er, ef, nt, ft);
    check("ch3_settle_rise", 32'(nr), 32'd1);
    drive_slot();
    BTN_IN[2] = 1'b1;
    BTN_IN[3] = 1'b0;
    er2 = -1; ef3 = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge CLK);
      if (BTN_RISE[2] && er2 < 0) er2 = k;
      if (BTN_FALL[3] && ef3 < 0) ef3 = k;
    end
    check("ch2_rise_seen", 32'(er2 > 0), 32'd1);
    check("ch2_ch3_same_cycle", 32'(er2), 32'(ef3));
    check("ch2_ch3_out", 32'(BTN_OUT), 32'b0111);

    // Release channel 0, freeze sampling after two differing ticks.
    wait_tick("align_tick");
    drive_slot();
    BTN_IN[0] = 1'b0;
    wait_tick("en_tick_1");
    wait_tick("en_tick_2");
    drive_slot();
    EN = 1'b0;
    watch(30, 0, nr, nf, er, ef, nt, ft);
    check("en0_no_ticks", 32'(nt), 32'd0);
    check("en0_no_fall", 32'(nf), 32'd0);
    check("en0_out_held", 32'(BTN_OUT[0]), 32'd1);
    drive_slot();
    EN = 1'b1;
    watch(35, 0, nr, nf, er, ef, nt, ft);
    check("en1_first_tick", 32'(ft), 32'd10);
    check("en1_fall_count", 32'(nf), 32'd1);
    check("en1_fall_after_two_ticks", 32'(ef), 32'd21);

    // Reset pulse in the middle of a channel-3 count.
    drive_slot();
    BTN_IN[3] = 1'b1;
    repeat (25) @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    check("rst_async_out", 32'(BTN_OUT), 32'd0);
    check("rst_async_tick", 32'(SAMPLE_TICK), 32'd0);
    check("rst_async_pulses", 32'(BTN_RISE | BTN_FALL), 32'd0);
    repeat (3) @(posedge CLK);
    #2;
    RST = 1'b0;
    watch(60, 3, nr, nf, er, ef, nt, ft);
    check("rst_restart_ch3_latency", 32'(er), 32'd41);
    check("rst_restart_out", 32'(BTN_OUT), 32'b1110);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global time bound.
  initial begin
    #100000;
    n_chk++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
